// File: rtl/mult_arbiter.sv
// Four-requester round-robin front end sharing one unsigned multiplier; 2-cycle request-to-result latency.
// Backpressure: res_ready low freezes S2, S1 holds, and grants stop once both stages are full.
module mult_arbiter #(
   parameter int W_a = 8,
   parameter int W_b = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [3:0]           i_req_valid,
   input  logic [4*W_a-1:0]     i_req_a,
   input  logic [4*W_b-1:0]     i_req_b,
   output logic [3:0]           o_req_ready,
   output logic                 o_res_valid,
   input  logic                 i_res_ready,
   output logic [W_a+W_b-1:0]   o_res_product,
   output logic [1:0]           o_res_id,
   output logic                 o_busy
);

   logic               r_op_valid;
   logic [W_a-1:0]     r_op_a;
   logic [W_b-1:0]     r_op_b;
   logic [1:0]         r_op_id;
   logic               r_res_valid;
   logic [W_a+W_b-1:0] r_res_product;
   logic [1:0]         r_res_id;
   logic [1:0]         r_last_grant;

   logic               w_advance;
   logic               w_s1_accept;
   logic               w_found;
   logic [1:0]         w_grant_id;
   logic [1:0]         w_idx;
   logic               w_xfer;
   logic [W_a+W_b-1:0] w_product;

   assign w_advance   = !r_res_valid || i_res_ready;
   assign w_s1_accept = !r_op_valid || w_advance;

   // Search begins one past the last granted requester; 2-bit wrap gives the mod-4 rotation.
   always_comb begin
      w_found    = 1'b0;
      w_grant_id = 2'd0;
      w_idx      = 2'd0;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_last_grant + 2'(k + 1);
         if (!w_found && i_req_valid[w_idx]) begin
            w_found    = 1'b1;
            w_grant_id = w_idx;
         end
      end
   end

   // Gated by reset so no grant is shown while the block is held in reset.
   assign o_req_ready = (w_found && w_s1_accept && i_rst_n) ? (4'b0001 << w_grant_id) : 4'b0000;
   assign w_xfer      = |(i_req_valid & o_req_ready);
   assign w_product   = (W_a+W_b)'(r_op_a) * (W_a+W_b)'(r_op_b);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op_valid   <= 1'b0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_id      <= 2'd0;
         r_last_grant <= 2'd3;
      end else if (w_xfer) begin
         r_op_valid   <= 1'b1;
         r_op_a       <= i_req_a[w_grant_id*W_a +: W_a];
         r_op_b       <= i_req_b[w_grant_id*W_b +: W_b];
         r_op_id      <= w_grant_id;
         r_last_grant <= w_grant_id;
      end else if (w_advance) begin
         r_op_valid   <= 1'b0;
      end
   end

   // Product/id only reload with a real operation so an idle S2 keeps its last value.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_res_valid   <= 1'b0;
         r_res_product <= '0;
         r_res_id      <= 2'd0;
      end else if (w_advance) begin
         r_res_valid <= r_op_valid;
         if (r_op_valid) begin
            r_res_product <= w_product;
            r_res_id      <= r_op_id;
         end
      end
   end

   assign o_res_valid   = r_res_valid;
   assign o_res_product = r_res_product;
   assign o_res_id      = r_res_id;
   assign o_busy        = r_op_valid || r_res_valid;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: grants push expected products, results pop and compare.
module tb_mult_arbiter;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] prod;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res_product;
   logic [1:0]  res_id;
   logic        busy;

   logic [7:0]  ta [4];
   logic [7:0]  tb_b [4];
   exp_t        sb [$];
   int          g_log [$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   assign req_a = {ta[3], ta[2], ta[1], ta[0]};
   assign req_b = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};

   mult_arbiter #(.W_a(8), .W_b(8)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_req_valid   (req_valid),
      .i_req_a       (req_a),
      .i_req_b       (req_b),
      .o_req_ready   (req_ready),
      .o_res_valid   (res_valid),
      .i_res_ready   (res_ready),
      .o_res_product (res_product),
      .o_res_id      (res_id),
      .o_busy        (busy)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (res_valid && res_ready) begin
            check_val("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check_val("res_product", 32'(res_product), 32'(e.prod));
               check_val("res_id", 32'(res_id), 32'(e.id));
            end
         end
         check_val("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
         check_val("ready_masked", 32'(req_ready & ~req_valid), 32'd0);
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back('{id: 2'(i), prod: 16'(ta[i]) * 16'(tb_b[i])});
               g_log.push_back(i);
            end
         end
      end
   end

   task automatic randomize_ops();
      for (int i = 0; i < 4; i++) begin
         ta[i]   = 8'($urandom_range(0, 255));
         tb_b[i] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      sb.delete();
      g_log.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      req_valid = 4'b0000;
      res_ready = 1'b1;
      while ((busy || sb.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, 32'(busy || sb.size() != 0), 32'd0);
   endtask

   initial begin
      int wait_n;
      logic [15:0] held_p;
      logic [1:0]  held_id;

      for (int i = 0; i < 4; i++) begin
         ta[i]   = 8'd0;
         tb_b[i] = 8'd0;
      end
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      res_ready = 1'b1;
      #3;
      check_val("rst_res_valid", 32'(res_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_req_ready", 32'(req_ready), 32'd0);
      check_val("rst_product", 32'(res_product), 32'd0);
      check_val("rst_res_id", 32'(res_id), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      req_valid = 4'b0000;

      // Single request from requester 2: result visible two cycles after the grant cycle.
      ta[2] = 8'd255; tb_b[2] = 8'd255;
      req_valid = 4'b0100;
      @(negedge clk);
      check_val("single_grant", 32'(req_ready), 32'h4);
      @(posedge clk); #1 req_valid = 4'b0000;
      @(negedge clk);
      check_val("single_lat1", 32'(res_valid), 32'd0);
      @(negedge clk);
      check_val("single_lat2", 32'(res_valid), 32'd1);
      check_val("single_product", 32'(res_product), 32'hFE01);
      check_val("single_id", 32'(res_id), 32'd2);
      drain("single_drain");

      // All four requesters continuously: one grant per cycle in order 0,1,2,3.
      do_reset();
      randomize_ops();
      req_valid = 4'b1111;
      repeat (12) begin
         @(posedge clk); #1 randomize_ops();
      end
      req_valid = 4'b0000;
      check_val("rr_count", 32'(g_log.size()), 32'd12);
      for (int k = 0; k < 12 && g_log.size() != 0; k++)
         check_val("rr_order", 32'(g_log.pop_front()), 32'(k % 4));
      drain("rr_drain");

      // Backpressure: only two operations enter while the consumer stalls.
      do_reset();
      res_ready = 1'b0;
      randomize_ops();
      req_valid = 4'b1111;
      held_p  = '0;
      held_id = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            check_val("bp_ready_zero", 32'(req_ready), 32'd0);
            check_val("bp_res_valid", 32'(res_valid), 32'd1);
            if (c == 2) begin
               held_p  = res_product;
               held_id = res_id;
            end else begin
               check_val("bp_product_stable", 32'(res_product), 32'(held_p));
               check_val("bp_id_stable", 32'(res_id), 32'(held_id));
            end
         end
         @(posedge clk); #1 randomize_ops();
      end
      check_val("bp_accepted", 32'(g_log.size()), 32'd2);
      res_ready = 1'b1;
      repeat (8) begin
         @(posedge clk); #1 randomize_ops();
      end
      drain("bp_drain");

      // Fairness between requesters 1 and 3.
      do_reset();
      randomize_ops();
      req_valid = 4'b1010;
      repeat (8) begin
         @(posedge clk); #1 randomize_ops();
      end
      req_valid = 4'b0000;
      check_val("fair_count", 32'(g_log.size()), 32'd8);
      for (int k = 0; k < 8 && g_log.size() != 0; k++)
         check_val("fair_order", 32'(g_log.pop_front()), (k % 2 == 0) ? 32'd1 : 32'd3);
      drain("fair_drain");

      // Reset while both stages are full.
      do_reset();
      res_ready = 1'b0;
      randomize_ops();
      req_valid = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      check_val("mid_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      sb.delete();
      g_log.delete();
      #1;
      check_val("mid_res_valid", 32'(res_valid), 32'd0);
      check_val("mid_busy", 32'(busy), 32'd0);
      check_val("mid_req_ready", 32'(req_ready), 32'd0);
      check_val("mid_product", 32'(res_product), 32'd0);
      req_valid = 4'b1100;
      res_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("mid_first_grant", 32'(req_ready), 32'h4);
      @(posedge clk); #1;
      drain("mid_drain");

      // Exhaustive operand sweep through requester 0.
      req_valid = 4'b0001;
      res_ready = 1'b1;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 256; b++) begin
            ta[0]   = 8'(a);
            tb_b[0] = 8'(b);
            wait_n  = 0;
            @(negedge clk);
            while (!req_ready[0] && wait_n < 10) begin
               @(negedge clk);
               wait_n++;
            end
            if (wait_n >= 10) check_val("exh_grant", 32'(req_ready[0]), 32'd1);
            @(posedge clk); #1;
         end
      end
      drain("exh_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
